// File: rtl/flow_ctrl_pkg.sv
// Shared types and defaults for the pipeline flow controller.
package flow_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } fc_state_e;

  localparam int unsigned FC_TIMEOUT_CYC_DEF = 32'd256;
  localparam int unsigned FC_CNT_W_DEF       = 32'd32;

  typedef struct packed {
    logic bk_pc;
    logic bk_ifid;
    logic bk_idex;
    logic bk_exmem;
    logic flush_ifid;
    logic flush_idex;
    logic jump_flag;
  } fc_ctrl_t;

  // Full pipeline freeze: every register holds, nothing flushed, no redirect.
  function automatic fc_ctrl_t fc_ctrl_freeze();
    fc_ctrl_t c;
    c            = '0;
    c.bk_pc      = 1'b1;
    c.bk_ifid    = 1'b1;
    c.bk_idex    = 1'b1;
    c.bk_exmem   = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/fc_hazard_unit.sv
// Load-use detector: a load in EX whose destination feeds an ID-stage source.
module fc_hazard_unit (
  input  logic [4:0] id_rs1_raddr,
  input  logic       id_rs1_re,
  input  logic [4:0] id_rs2_raddr,
  input  logic       id_rs2_re,
  input  logic [4:0] idex_reg_waddr,
  input  logic       idex_reg_we,
  input  logic       idex_mtype,
  input  logic       idex_mem_rw,
  output logic       load_use
);

  logic is_load_s;
  logic rs1_hit_s;
  logic rs2_hit_s;

  // x0 is never a real dependency, so it is excluded from the load qualifier.
  assign is_load_s = idex_mtype & ~idex_mem_rw & idex_reg_we & (idex_reg_waddr != 5'd0);
  assign rs1_hit_s = id_rs1_re & (id_rs1_raddr == idex_reg_waddr);
  assign rs2_hit_s = id_rs2_re & (id_rs2_raddr == idex_reg_waddr);
  assign load_use  = is_load_s & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/flow_ctrl.sv
// Pipeline flow controller: prioritised block/flush/redirect generation,
// memory-wait FSM with timeout, and a saturating stall-cycle counter.
module flow_ctrl
  import flow_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = FC_TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W       = FC_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_raddr_i,
  input  logic             id_rs1_re_i,
  input  logic [4:0]       id_rs2_raddr_i,
  input  logic             id_rs2_re_i,
  input  logic [4:0]       idex_reg_waddr_i,
  input  logic             idex_reg_we_i,
  input  logic             idex_mtype_i,
  input  logic             idex_mem_rw_i,
  input  logic             ex_jump_flag_i,
  input  logic [31:0]      ex_jump_pc_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             fc_bk_pc_o,
  output logic             fc_bk_ifid_o,
  output logic             fc_bk_idex_o,
  output logic             fc_bk_exmem_o,
  output logic             fc_flush_ifid_o,
  output logic             fc_flush_idex_o,
  output logic             fc_jump_flag_o,
  output logic [31:0]      fc_jump_pc_o,
  output logic [CNT_W-1:0] fc_stall_cnt_o,
  output logic             fc_timeout_o
);

  localparam int unsigned     WC_W   = $clog2(TIMEOUT_CYC + 32'd1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT_CYC);
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1'b1);

  fc_state_e        state_r;
  logic [WC_W-1:0]  wait_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             timeout_r;
  logic             mem_stall_s;
  logic             load_use_s;
  fc_ctrl_t         ctrl_s;
  logic [31:0]      jump_pc_s;

  assign mem_stall_s = mem_req_i & ~mem_ready_i;

  fc_hazard_unit u_hazard (
    .id_rs1_raddr   (id_rs1_raddr_i),
    .id_rs1_re      (id_rs1_re_i),
    .id_rs2_raddr   (id_rs2_raddr_i),
    .id_rs2_re      (id_rs2_re_i),
    .idex_reg_waddr (idex_reg_waddr_i),
    .idex_reg_we    (idex_reg_we_i),
    .idex_mtype     (idex_mtype_i),
    .idex_mem_rw    (idex_mem_rw_i),
    .load_use       (load_use_s)
  );

  // Priority mux: memory wait masks a jump so the branch stays in ID/EX.
  always_comb begin
    ctrl_s    = '0;
    jump_pc_s = 32'h0000_0000;
    if (!rst_n) begin
      ctrl_s = '0;
    end else if ((state_r == ST_ERR) || mem_stall_s) begin
      ctrl_s = fc_ctrl_freeze();
    end else if (ex_jump_flag_i) begin
      ctrl_s.jump_flag  = 1'b1;
      ctrl_s.flush_ifid = 1'b1;
      ctrl_s.flush_idex = 1'b1;
      jump_pc_s         = ex_jump_pc_i;
    end else if (load_use_s) begin
      ctrl_s.bk_pc      = 1'b1;
      ctrl_s.bk_ifid    = 1'b1;
      ctrl_s.flush_idex = 1'b1;
    end else begin
      ctrl_s = '0;
    end
  end

  // Wait/timeout FSM and the saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      wait_cnt_r  <= '0;
      stall_cnt_r <= '0;
      timeout_r   <= 1'b0;
    end else begin
      if (ctrl_s.bk_pc && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
      end
      case (state_r)
        ST_RUN: begin
          if (mem_stall_s) begin
            state_r    <= ST_MEM_WAIT;
            wait_cnt_r <= WC_ONE;
          end else begin
            wait_cnt_r <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_stall_s) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
          end else if (wait_cnt_r < WC_MAX) begin
            wait_cnt_r <= wait_cnt_r + WC_ONE;
          end else begin
            state_r    <= ST_ERR;
            wait_cnt_r <= '0;
            timeout_r  <= 1'b1;
          end
        end
        ST_ERR: begin
          timeout_r <= 1'b1;
        end
        default: begin
          // An illegal encoding is treated as a fault and freezes the pipe.
          state_r   <= ST_ERR;
          timeout_r <= 1'b1;
        end
      endcase
    end
  end

  assign fc_bk_pc_o      = ctrl_s.bk_pc;
  assign fc_bk_ifid_o    = ctrl_s.bk_ifid;
  assign fc_bk_idex_o    = ctrl_s.bk_idex;
  assign fc_bk_exmem_o   = ctrl_s.bk_exmem;
  assign fc_flush_ifid_o = ctrl_s.flush_ifid;
  assign fc_flush_idex_o = ctrl_s.flush_idex;
  assign fc_jump_flag_o  = ctrl_s.jump_flag;
  assign fc_jump_pc_o    = jump_pc_s;
  assign fc_stall_cnt_o  = stall_cnt_r;
  assign fc_timeout_o    = timeout_r;

endmodule
